// File: rtl/hash_arbiter.sv
// hash_arbiter
// Round-robin arbiter and sequencer sharing one Keccak-based hash core
// (SHAKE-128 / SHAKE-256 / SHA3-512) among NREQ requesters.
//
// Ports:
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   i_req   [NREQ]        per-requester request level
//   i_mode  [2*NREQ]      per-requester mode (0 SHAKE-128, 1 SHAKE-256, 2 SHA3-512, 3 invalid)
//   i_in    [272*NREQ]    per-requester absorb data
//   i_more  [NREQ]        squeeze another block, sampled while own o_valid is high
//   o_gnt   [NREQ]        one-hot owner, held from grant through STOP
//   o_valid [NREQ]        one-cycle pulse, o_out holds a block for that requester
//   o_out   [1344]        registered copy of the core output block
//   o_err                 one-cycle pulse on invalid mode or timeout
//   o_busy                arbiter not idle
//   o_hash_en [2]         core enable: 00 WAIT, 01 START, 10 STOP
//   o_hash_mode, o_hash_in  latched mode/data of the owner, driven to the core
//   i_hash_done, i_hash_out core done level and output block
module hash_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [NREQ-1:0]       i_req,
    input  logic [2*NREQ-1:0]     i_mode,
    input  logic [272*NREQ-1:0]   i_in,
    input  logic [NREQ-1:0]       i_more,
    output logic [NREQ-1:0]       o_gnt,
    output logic [NREQ-1:0]       o_valid,
    output logic [1343:0]         o_out,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [1:0]            o_hash_en,
    output logic [1:0]            o_hash_mode,
    output logic [271:0]          o_hash_in,
    input  logic                  i_hash_done,
    input  logic [1343:0]         i_hash_out
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT,
        S_STOP,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      mode_q, mode_d;
    logic [271:0]    in_q, in_d;
    logic [1343:0]   out_q, out_d;

    logic            found;
    int unsigned     pick_i;
    logic            done_rise;

    assign done_rise = i_hash_done & ~done_q;

    // First set request searching upward from ptr+1, wrapping at NREQ.
    always_comb begin
        found  = 1'b0;
        pick_i = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned cand;
            cand = ptr_q + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                pick_i = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = i_hash_done;
        gnt_d   = gnt_q;
        mode_d  = mode_q;
        in_d    = in_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d         = OW'(pick_i);
                    mode_d          = i_mode[2*pick_i +: 2];
                    in_d            = i_in[272*pick_i +: 272];
                    gnt_d           = '0;
                    gnt_d[pick_i]   = 1'b1;
                    state_d = (i_mode[2*pick_i +: 2] == 2'd3) ? S_ERR : S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Only a rising edge of done counts; a level left high by the
                // previous squeeze block must not complete this one.
                if (done_rise) begin
                    out_d   = i_hash_out;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT - 1)) state_d = S_ERR;
                end
            end
            S_OUT: begin
                if (i_more[owner_q] && mode_q != 2'd2) state_d = S_START;
                else                                    state_d = S_STOP;
            end
            S_ERR: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                ptr_d   = owner_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= OW'(NREQ - 1);
            cnt_q   <= '0;
            done_q  <= 1'b0;
            gnt_q   <= '0;
            mode_q  <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            gnt_q   <= gnt_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        o_hash_en = 2'b00;
        if (state_q == S_START) o_hash_en = 2'b01;
        if (state_q == S_STOP)  o_hash_en = 2'b10;
    end

    assign o_valid     = (state_q == S_OUT) ? gnt_q : '0;
    assign o_err       = (state_q == S_ERR);
    assign o_busy      = (state_q != S_IDLE);
    assign o_gnt       = gnt_q;
    assign o_out       = out_q;
    assign o_hash_mode = mode_q;
    assign o_hash_in   = in_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter
// Bench for hash_arbiter with a behavioural hash-core stub. The stub returns
// the SHA3-512("abc") digest for that input and a deterministic function of
// (mode, data, block index) otherwise; a monitor keeps a round-robin model.
module tb_hash_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 40;
    localparam logic [511:0] KAT_ABC = 512'hb751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    mode;
    logic [272*NREQ-1:0]  in;
    logic [NREQ-1:0]      more;
    logic [NREQ-1:0]      o_gnt, o_valid;
    logic [1343:0]        o_out;
    logic                 o_err, o_busy;
    logic [1:0]           o_hash_en, o_hash_mode;
    logic [271:0]         o_hash_in;
    logic                 hdone;
    logic [1343:0]        hout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hash_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_mode(mode), .i_in(in),
        .i_more(more), .o_gnt(o_gnt), .o_valid(o_valid), .o_out(o_out),
        .o_err(o_err), .o_busy(o_busy), .o_hash_en(o_hash_en),
        .o_hash_mode(o_hash_mode), .o_hash_in(o_hash_in),
        .i_hash_done(hdone), .i_hash_out(hout)
    );

    task automatic check(input string name, input logic [1343:0] act, input logic [1343:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1343:0] stub_block(input logic [1:0] m, input logic [271:0] d, input int b);
        logic [1343:0] r;
        r = '0;
        if (m == 2'd2 && d == 272'h616263 && b == 0) begin
            r[511:0] = KAT_ABC;
        end else begin
            for (int w = 0; w < 42; w++) begin
                logic [31:0] k;
                k = 32'(w + 1);
                r[w*32 +: 32] = d[((w*7) % 240) +: 32] ^ (32'h9E3779B9 * k) ^ {16'(b), 14'd0, m};
            end
        end
        return r;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Hash core stub: done drops on START, rises stub_lat cycles later
    // (stub_lat == 0 means the core never finishes).
    int stub_lat = 3;
    int cd, sblk;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdone <= 1'b0; hout <= '0; cd <= 0; sblk <= 0;
        end else begin
            if (o_hash_en == 2'b01) begin
                hdone <= 1'b0;
                cd    <= stub_lat;
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    hdone <= 1'b1;
                    hout  <= stub_block(o_hash_mode, o_hash_in, sblk);
                    sblk  <= sblk + 1;
                end
            end
            if (o_hash_en == 2'b10) sblk <= 0;
        end
    end

    // Reference model: round-robin choice from the last served owner, and
    // expected block contents for each o_valid of the current transaction.
    int m_ptr = NREQ - 1;
    int m_owner = 0;
    int m_blk = 0;
    logic [1:0]          m_mode;
    logic [271:0]        m_in;
    logic [NREQ-1:0]     s_req;
    logic [2*NREQ-1:0]   s_mode;
    logic [272*NREQ-1:0] s_in;
    logic                s_busy, s_rstn;

    always @(posedge clk) begin
        s_req = req; s_mode = mode; s_in = in; s_busy = o_busy; s_rstn = rstn;
        #1;
        if (!s_rstn || !rstn) begin
            m_ptr = NREQ - 1;
        end else begin
            check("gnt_onehot", $onehot0(o_gnt), 1);
            check("gnt_vs_busy", (o_gnt != 0), o_busy);
            if (!s_busy && s_req != 0) begin
                int e;
                e = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_ptr + k) % NREQ;
                    if (s_req[c] && e < 0) e = c;
                end
                check("grant_owner", o_gnt, 3'(1) << e);
                m_owner = e;
                m_mode  = s_mode[2*e +: 2];
                m_in    = s_in[272*e +: 272];
                m_blk   = 0;
            end
            if (o_valid != 0) begin
                check("valid_owner", o_valid, 3'(1) << m_owner);
                check("block_data", o_out, stub_block(m_mode, m_in, m_blk));
                m_blk++;
            end
            if (s_busy && !o_busy) m_ptr = m_owner;
        end
    end

    task automatic do_reset();
        rstn = 1'b0; req = '0; more = '0; mode = '0; in = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_gnt, o_valid, o_err, o_busy, o_hash_en, o_hash_mode}, 0);
        check({name, "_out"}, o_out, 0);
        check({name, "_hin"}, o_hash_in, 0);
    endtask

    // Run one transaction until the arbiter returns to idle. The owner's
    // request is dropped once granted; i_more follows the requested extras.
    task automatic do_txn(input logic [NREQ-1:0] rq, input logic [2*NREQ-1:0] md, input int extra,
                          output int owner, output int nval, output int nerr,
                          output int nstart, output int nstop);
        int n;
        bit seen;
        n = 0; seen = 0; owner = -1; nval = 0; nerr = 0; nstart = 0; nstop = 0;
        @(negedge clk);
        req = rq; mode = md;
        for (int j = 0; j < 272*NREQ; j++) in[j] = 1'($urandom_range(0, 1));
        more = (extra > 0) ? '1 : '0;
        while (n < 600) begin
            @(posedge clk); #1; n++;
            if (o_busy) seen = 1;
            if (o_gnt != 0 && owner < 0) begin
                owner = idx_of(o_gnt);
                req   = req & ~o_gnt;
            end
            if (o_hash_en == 2'b01) nstart++;
            if (o_hash_en == 2'b10) nstop++;
            if (o_err) nerr++;
            if (o_valid != 0) begin
                nval++;
                more = (nval <= extra) ? '1 : '0;
            end
            if (seen && !o_busy) break;
        end
        check("txn_complete", {seen, o_busy}, 2'b10);
        more = '0;
    endtask

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [2*NREQ-1:0] mode;
        int                extra;
        int                exp_owner;
        int                exp_val;
        int                exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ow, nv, ne, ns, np;
        vecs[0] = '{3'b001, 6'b000010, 0, 0, 1, 0};
        vecs[1] = '{3'b110, 6'b010000, 1, 1, 2, 0};
        vecs[2] = '{3'b101, 6'b110000, 0, 2, 0, 1};
        vecs[3] = '{3'b011, 6'b000001, 2, 0, 3, 0};
        vecs[4] = '{3'b001, 6'b000010, 2, 0, 1, 0};
        vecs[5] = '{3'b111, 6'b000000, 0, 1, 1, 0};
        vecs[6] = '{3'b100, 6'b000000, 0, 2, 1, 0};
        vecs[7] = '{3'b111, 6'b000000, 0, 0, 1, 0};

        // Reset values
        rstn = 1'b0; req = '0; more = '0; mode = '0; in = '0;
        #3;
        check_all_zero("reset_values");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // SHA3-512("abc") on requester 1, cycle-exact
        stub_lat = 3;
        @(negedge clk);
        req = 3'b010; mode = 6'b001000; in = '0; in[272 +: 272] = 272'h616263;
        @(posedge clk); #1;
        check("abc_start_en", o_hash_en, 2'b01);
        check("abc_gnt", o_gnt, 3'b010);
        check("abc_hmode", o_hash_mode, 2'd2);
        check("abc_hin", o_hash_in, 272'h616263);
        @(posedge clk); #1;
        check("abc_wait_en", o_hash_en, 2'b00);
        begin
            logic pd;
            bit got;
            pd = hdone; got = 0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(posedge clk); #1;
                if (hdone && !pd) begin
                    got = 1;
                    @(posedge clk); #1;
                    check("abc_valid_latency", o_valid, 3'b010);
                end
                pd = hdone;
            end
            check("abc_done_seen", got, 1);
        end
        check("abc_digest", o_out[575:0], {64'd0, KAT_ABC});
        check("abc_high_zero", o_out[1343:576], 0);
        req = '0;
        @(posedge clk); #1;
        check("abc_stop_en", {o_hash_en, o_gnt}, {2'b10, 3'b010});
        @(posedge clk); #1;
        check("abc_idle", {o_busy, o_gnt}, 0);

        // Table-driven transactions from a known pointer
        do_reset();
        foreach (vecs[v]) begin
            stub_lat = 2 + v % 3;
            do_txn(vecs[v].req, vecs[v].mode, vecs[v].extra, ow, nv, ne, ns, np);
            check($sformatf("vec%0d_owner", v), ow, vecs[v].exp_owner);
            check($sformatf("vec%0d_valids", v), nv, vecs[v].exp_val);
            check($sformatf("vec%0d_err", v), ne, vecs[v].exp_err);
            check($sformatf("vec%0d_starts", v), ns, vecs[v].exp_val);
            check($sformatf("vec%0d_stops", v), np, 1);
        end

        // Fairness with all requests held
        do_reset();
        stub_lat = 2;
        begin
            int order[4];
            int g, idle_run, n;
            logic prev_busy;
            g = 0; idle_run = 0; n = 0; prev_busy = 0;
            @(negedge clk);
            req = 3'b111;
            while (g < 4 && n < 400) begin
                @(posedge clk); #1; n++;
                if (o_busy && !prev_busy) begin
                    order[g] = idx_of(o_gnt);
                    if (g > 0) check("fair_idle_gap", idle_run, 1);
                    g++;
                end
                if (!o_busy) idle_run++; else idle_run = 0;
                prev_busy = o_busy;
            end
            check("fair_grants", g, 4);
            for (int i = 0; i < 4; i++) check($sformatf("fair_order%0d", i), order[i], i % 3);
            req = '0;
            for (int i = 0; i < 100 && o_busy; i++) begin @(posedge clk); #1; end
            check("fair_drain", o_busy, 0);
        end

        // Invalid mode on requester 0, requester 1 pending
        do_reset();
        stub_lat = 3;
        do_txn(3'b011, 6'b000011, 0, ow, nv, ne, ns, np);
        check("inv_owner", ow, 0);
        check("inv_err_starts_valids", {32'(ne), 32'(ns), 32'(nv), 32'(np)}, {32'd1, 32'd0, 32'd0, 32'd1});
        do_txn(req, 6'b000011, 0, ow, nv, ne, ns, np);
        check("inv_next_owner", ow, 1);
        check("inv_next_valids", nv, 1);

        // Timeout: core never finishes
        do_reset();
        stub_lat = 0;
        begin
            int n, st, et, nv2;
            bit stop_ok;
            n = 0; st = -1; et = -1; nv2 = 0; stop_ok = 0;
            @(negedge clk);
            req = 3'b001; mode = 6'b000000;
            while (n < 200 && et < 0) begin
                @(posedge clk); #1; n++;
                if (o_hash_en == 2'b01 && st < 0) st = n;
                if (o_err) et = n;
                if (o_valid != 0) nv2++;
            end
            req = '0;
            @(posedge clk); #1;
            check("to_stop_after_err", o_hash_en, 2'b10);
            check("to_err_delay", et - st, TO);
            check("to_no_valid", nv2 + (o_valid != 0), 0);
            @(posedge clk); #1;
            check("to_idle", o_busy, 0);
        end

        // Asynchronous reset during WAIT of a SHAKE-256 job
        do_reset();
        stub_lat = 0;
        @(negedge clk);
        req = 3'b001; mode = 6'b000001;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_busy", {o_busy, o_hash_en, o_hash_mode}, {1'b1, 2'b00, 2'd1});
        #2 rstn = 1'b0;
        #1 check_all_zero("rst_async");
        repeat (2) @(negedge clk);
        rstn = 1'b1; req = '0;
        stub_lat = 3;
        do_txn(3'b001, 6'b000001, 0, ow, nv, ne, ns, np);
        check("rst_after_owner", ow, 0);
        check("rst_after_valids", nv, 1);

        // Randomized transactions against the model
        for (int r = 0; r < 40; r++) begin
            logic [NREQ-1:0]   rq;
            logic [2*NREQ-1:0] md;
            int ex, ev;
            logic [1:0] om;
            rq = NREQ'($urandom_range(1, 7));
            md = (2*NREQ)'($urandom);
            ex = $urandom_range(0, 2);
            stub_lat = $urandom_range(1, 5);
            do_txn(rq, md, ex, ow, nv, ne, ns, np);
            check("rand_owner_found", (ow >= 0), 1);
            if (ow >= 0) begin
                om = md[2*ow +: 2];
                ev = (om == 2'd3) ? 0 : (om == 2'd2) ? 1 : ex + 1;
                check("rand_valids", nv, ev);
                check("rand_err", ne, (om == 2'd3) ? 1 : 0);
                check("rand_starts", ns, ev);
                check("rand_stops", np, 1);
            end
        end
        req = '0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one hash core (SHAKE-128 / SHAKE-256 / SHA3-512 over a single Keccak-f[1600]) among NREQ requesters, e.g. matrix generation, CBD sampling and G/H.
- Grants the core to one requester and captures that requester's mode and input.
- Drives the core's WAIT/START/STOP enable, detects block completion, and returns registered output blocks.
- Supports multi-block XOF squeezing for the SHAKE modes.

Parameters:
NREQ, 3, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (≥ 30)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_req  in  NREQ  per-requester request level
i_mode  in  2*NREQ  per-requester mode: 0 SHAKE-128, 1 SHAKE-256, 2 SHA3-512, 3 invalid
i_in  in  272*NREQ  per-requester absorb data (slice k = bits 272k+271:272k)
i_more  in  NREQ  per-requester squeeze-another-block, sampled during own o_valid
o_gnt  out  NREQ  one-hot owner
o_valid  out  NREQ  one-cycle pulse: o_out holds a block for that requester
o_out  out  1344  registered copy of core output block
o_err  out  1  one-cycle pulse: invalid mode or timeout
o_busy  out  1  state != IDLE
o_hash_en  out  2  to core: 00 WAIT, 01 START, 10 STOP
o_hash_mode  out  2  to core mode
o_hash_in  out  272  to core data
i_hash_done  in  1  core done level
i_hash_out  in  1344  core output

Behaviour:
- Reset (async, i_rstn=0): state IDLE, rr pointer = NREQ-1, timeout counter 0, done_q 0.
- Reset values of outputs: o_gnt 0, o_valid 0, o_out 0, o_err 0, o_busy 0, o_hash_en 00, o_hash_mode 0, o_hash_in 0.
- Reset mid-operation abandons the transaction; no o_valid is produced.
- done_q registers i_hash_done every cycle. done_rise = i_hash_done & ~done_q.
- States: IDLE, START, WAIT, OUT, STOP, ERR.
- IDLE:
  - If any i_req is set, choose the first set bit searching from ptr+1 modulo NREQ.
  - Latch owner, that requester's mode into o_hash_mode and its i_in slice into o_hash_in.
  - Set o_gnt one-hot and go to START, or to ERR if the latched mode is 3.
  - o_hash_mode and o_hash_in stay stable until the return to IDLE.
- START: o_hash_en=01 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT:
  - o_hash_en=00.
  - On done_rise: o_out <= i_hash_out, go to OUT.
  - Otherwise increment the counter; when counter == TIMEOUT-1, go to ERR.
  - A stale-high done left over from the previous squeeze block is ignored; only the rising edge counts.
- OUT:
  - o_valid[owner]=1 for this cycle only.
  - If i_more[owner]=1 and mode != 2: go to START (next squeeze block; the core permutes its own state).
  - Otherwise go to STOP. i_more is ignored for SHA3-512.
- ERR: o_err=1 for one cycle; go to STOP.
- STOP:
  - o_hash_en=10 for one cycle; ptr <= owner.
  - o_gnt is cleared on the transition to IDLE.
- o_gnt is held from the grant cycle through the STOP cycle.
- i_req deasserted mid-transaction is ignored; there is no abort. The requester drops i_req after its final o_valid.
- A requester that keeps i_req high gets a new transaction, but only after the other pending requesters (round-robin fairness).
- Requests arriving in any non-IDLE state wait. Simultaneous requests are resolved purely by the pointer.
- Latency:
  - Request seen in IDLE at cycle t: START at t+1, WAIT from t+2.
  - done_rise at cycle d: o_valid at d+1, STOP at d+2, IDLE at d+3.
  - Earliest next START is d+4.
  - Each additional squeeze block: START at d+2 after its o_valid.

Test Plan:
- Single SHA3-512, i_req[1]=1, i_in="abc" padded into the low 24 bits of slice 1, i_more=0 → exactly one o_valid[1]; o_out[575:0] equals the SHA3-512 known-answer value; o_out[1343:576]=0; o_hash_en sequence 01…00…10.
- i_req=3'b111 held, each requester taking one block → grant order 0,1,2,0; no two o_gnt bits ever set; o_busy low exactly one cycle between transactions.
- SHAKE-128 on requester 2 with i_more high for two o_valid pulses, then low → three o_valid[2] pulses; three 01 pulses on o_hash_en; blocks match the first 3×1344 XOF bits; a single STOP at the end.
- i_mode slice 0 = 3 with i_req[0]=1 → no START issued, o_err pulse, STOP, return to IDLE; requester 1 pending is then served normally.
- Core stub never asserts done → o_err exactly TIMEOUT cycles after START; STOP issued; no o_valid.
- i_rstn pulled low during WAIT of a SHAKE-256 job → all outputs 0 immediately (asynchronous); after release, a new request from requester 0 completes with the correct digest.
